// File: rtl/riscv_pkg.sv
// Shared RV32 constants and helpers used by the fetch stage.
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] RV_NOP_INST      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        NPC_SEQ      = 2'd0,
        NPC_HOLD     = 2'd1,
        NPC_REDIRECT = 2'd2
    } npc_sel_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset, bubble, load and hold controls.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = RV_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic [XLEN-1:0] o_inst,
    output logic            o_valid
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_inst;
    logic            r_valid;

    // A bubble clears the whole entry so a squashed PC never leaks downstream.
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_pc4   <= i_pc + INST_BYTES;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID capture.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = RV_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [XLEN-1:0] ifid_inst,
    output logic            ifid_valid,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fetch_cnt
);
    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] r_fetch_cnt;
    npc_sel_e        w_npc_sel;
    logic [XLEN-1:0] w_pc_next;
    logic            w_load;

    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (redirect)
            w_npc_sel = NPC_REDIRECT;
        else if (stall)
            w_npc_sel = NPC_HOLD;
    end

    always_comb begin
        w_pc_next = r_pc + INST_BYTES;
        case (w_npc_sel)
            NPC_REDIRECT: w_pc_next = align_word(redirect_pc);
            NPC_HOLD:     w_pc_next = r_pc;
            default:      w_pc_next = r_pc + INST_BYTES;
        endcase
    end

    assign w_load = (w_npc_sel == NPC_SEQ);

    // RESET_PC is word-aligned on load so pc_o[1:0] stays zero even for an odd parameter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= align_word(RESET_PC);
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_pc        <= w_pc_next;
            r_misalign  <= redirect && (redirect_pc[1:0] != 2'b00);
            if (w_load)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (redirect),
        .i_pc     (r_pc),
        .i_inst   (inst_i),
        .o_pc     (ifid_pc),
        .o_pc4    (ifid_pc4),
        .o_inst   (ifid_inst),
        .o_valid  (ifid_valid)
    );

    assign pc_o           = r_pc;
    assign misalign_fault = r_misalign;
    assign fetch_cnt      = r_fetch_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized run against a cycle model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_o, inst_i, ifid_pc, ifid_pc4, ifid_inst, fetch_cnt;
    logic        ifid_valid, misalign_fault;
    logic [31:0] pc_w, inst_w, ifid_pc_w, ifid_pc4_w, ifid_inst_w, fetch_cnt_w;
    logic        ifid_valid_w, misalign_w;
    logic        mem_hash = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Reference state: what each visible output must be after the latest edge.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
        return h ? (a ^ 32'hA5C3_5A3C) + {a[15:0], a[31:16]} : a;
    endfunction

    assign inst_i = mem_word(pc_o, mem_hash);
    assign inst_w = mem_word(pc_w, mem_hash);

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_o(pc_o), .inst_i(inst_i), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_inst(ifid_inst), .ifid_valid(ifid_valid), .misalign_fault(misalign_fault),
        .fetch_cnt(fetch_cnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_o(pc_w), .inst_i(inst_w), .ifid_pc(ifid_pc_w), .ifid_pc4(ifid_pc4_w),
        .ifid_inst(ifid_inst_w), .ifid_valid(ifid_valid_w), .misalign_fault(misalign_w),
        .fetch_cnt(fetch_cnt_w)
    );

    // Apply one clock edge with the current inputs and advance the model alongside.
    task automatic tick();
        logic [31:0] fetched;
        fetched = mem_word(m_pc, mem_hash);
        if (rst) begin
            m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0;
            m_mis = (redirect_pc % 4) != 0;
        end else if (stall) begin
            m_mis = 0;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = fetched; m_valid = 1;
            m_cnt = m_cnt + 1; m_pc = m_pc + 4; m_mis = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic d, input logic [31:0] dp);
        rst = r; stall = s; redirect = d; redirect_pc = dp;
    endtask

    task automatic test_reset();
        mem_hash = 1'b0;
        set_in(1, 1, 1, 32'h0000_0123);
        tick();
        set_in(1, 0, 0, 0);
        tick();
        n_checks++;
        if (pc_o !== 32'h0 || ifid_pc !== 0 || ifid_pc4 !== 0 || ifid_inst !== NOP ||
            ifid_valid !== 1'b0 || misalign_fault !== 1'b0 || fetch_cnt !== 0) begin
            n_errors++;
            $display("FAIL reset: pc=%h ipc=%h ipc4=%h inst=%h v=%b mis=%b cnt=%0d required pc=0 ipc=0 ipc4=0 inst=%h v=0 mis=0 cnt=0",
                     pc_o, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, misalign_fault, fetch_cnt, NOP);
        end
        n_checks++;
        if (pc_w !== 32'hFFFF_FFF8) begin
            n_errors++;
            $display("FAIL reset_pc_param: pc=%h required FFFFFFF8", pc_w);
        end
        $display("reset: pc=%h inst=%h valid=%b cnt=%0d", pc_o, ifid_inst, ifid_valid, fetch_cnt);
    endtask

    task automatic test_run();
        set_in(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (pc_o !== 32'(4 * i) || ifid_inst !== 32'(4 * (i - 1)) || ifid_pc !== 32'(4 * (i - 1)) ||
                ifid_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL run_%0d: pc=%h inst=%h ipc=%h v=%b required pc=%h inst=%h ipc=%h v=1",
                         i, pc_o, ifid_inst, ifid_pc, ifid_valid, 4 * i, 4 * (i - 1), 4 * (i - 1));
            end
            $display("run: pc=%h ifid_inst=%h cnt=%0d", pc_o, ifid_inst, fetch_cnt);
        end
        n_checks++;
        if (fetch_cnt !== 32'd4) begin
            n_errors++;
            $display("FAIL run_count: cnt=%0d required 4", fetch_cnt);
        end
    endtask

    task automatic test_wrap();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (pc_w !== 32'h0 || ifid_pc_w !== 32'hFFFF_FFFC || ifid_pc4_w !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap: pc=%h ipc=%h ipc4=%h required pc=0 ipc=FFFFFFFC ipc4=0",
                     pc_w, ifid_pc_w, ifid_pc4_w);
        end
        tick();
        n_checks++;
        if (pc_w !== 32'h4 || ifid_pc_w !== 32'h0 || ifid_pc4_w !== 32'h4 || fetch_cnt_w !== 3) begin
            n_errors++;
            $display("FAIL wrap_after: pc=%h ipc=%h ipc4=%h cnt=%0d required 4 0 4 3",
                     pc_w, ifid_pc_w, ifid_pc4_w, fetch_cnt_w);
        end
        $display("wrap: pc=%h ifid_pc=%h ifid_pc4=%h", pc_w, ifid_pc_w, ifid_pc4_w);
    endtask

    task automatic test_stall();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        tick();
        set_in(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pc_o !== 32'h8 || ifid_pc !== 32'h4 || ifid_pc4 !== 32'h8 || ifid_inst !== 32'h4 ||
                ifid_valid !== 1'b1 || fetch_cnt !== 32'd2) begin
                n_errors++;
                $display("FAIL stall_%0d: pc=%h ipc=%h ipc4=%h inst=%h v=%b cnt=%0d required 8 4 8 4 1 2",
                         i, pc_o, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, fetch_cnt);
            end
            $display("stall: pc=%h ifid_pc=%h cnt=%0d", pc_o, ifid_pc, fetch_cnt);
        end
        set_in(0, 0, 0, 0);
        tick();
        n_checks++;
        if (pc_o !== 32'hC || ifid_inst !== 32'h8 || fetch_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_resume: pc=%h inst=%h cnt=%0d required C 8 3", pc_o, ifid_inst, fetch_cnt);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] cnt_before;
        cnt_before = m_cnt;
        set_in(0, 1, 1, 32'h0000_0100);
        tick();
        n_checks++;
        if (pc_o !== 32'h100 || ifid_valid !== 1'b0 || ifid_inst !== NOP || misalign_fault !== 1'b0 ||
            fetch_cnt !== cnt_before) begin
            n_errors++;
            $display("FAIL redir_stall: pc=%h v=%b inst=%h mis=%b cnt=%0d required 100 0 %h 0 %0d",
                     pc_o, ifid_valid, ifid_inst, misalign_fault, fetch_cnt, NOP, cnt_before);
        end
        set_in(0, 1, 0, 0);
        tick();
        n_checks++;
        if (pc_o !== 32'h100 || ifid_valid !== 1'b0 || ifid_inst !== NOP || fetch_cnt !== cnt_before) begin
            n_errors++;
            $display("FAIL redir_then_stall: pc=%h v=%b inst=%h cnt=%0d required 100 0 %h %0d",
                     pc_o, ifid_valid, ifid_inst, fetch_cnt, NOP, cnt_before);
        end
        $display("redirect+stall: pc=%h valid=%b inst=%h", pc_o, ifid_valid, ifid_inst);
    endtask

    task automatic test_misalign();
        set_in(0, 0, 1, 32'h0000_0203);
        tick();
        n_checks++;
        if (pc_o !== 32'h200 || misalign_fault !== 1'b1 || pc_o[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL misalign: pc=%h mis=%b required 200 1", pc_o, misalign_fault);
        end
        set_in(0, 0, 0, 0);
        tick();
        n_checks++;
        if (misalign_fault !== 1'b0 || pc_o !== 32'h204 || ifid_pc !== 32'h200) begin
            n_errors++;
            $display("FAIL misalign_pulse: mis=%b pc=%h ipc=%h required 0 204 200",
                     misalign_fault, pc_o, ifid_pc);
        end
        set_in(0, 0, 1, 32'h0000_0300);
        tick();
        n_checks++;
        if (misalign_fault !== 1'b0 || pc_o !== 32'h300) begin
            n_errors++;
            $display("FAIL aligned_redirect: mis=%b pc=%h required 0 300", misalign_fault, pc_o);
        end
        $display("misalign: pc=%h mis=%b", pc_o, misalign_fault);
    endtask

    task automatic test_midreset();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (ifid_valid !== 1'b1 || fetch_cnt !== 32'd7) begin
            n_errors++;
            $display("FAIL midreset_pre: v=%b cnt=%0d required 1 7", ifid_valid, fetch_cnt);
        end
        set_in(1, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_valid !== 1'b0 || fetch_cnt !== 32'd0 || pc_o !== 32'h0 || ifid_inst !== NOP) begin
            n_errors++;
            $display("FAIL midreset: v=%b cnt=%0d pc=%h inst=%h required 0 0 0 %h",
                     ifid_valid, fetch_cnt, pc_o, ifid_inst, NOP);
        end
        set_in(0, 0, 0, 0);
        tick();
        n_checks++;
        if (ifid_inst !== 32'h0 || ifid_valid !== 1'b1 || pc_o !== 32'h4 || fetch_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL post_reset_capture: inst=%h v=%b pc=%h cnt=%0d required 0 1 4 1",
                     ifid_inst, ifid_valid, pc_o, fetch_cnt);
        end
        $display("midreset: pc=%h valid=%b cnt=%0d", pc_o, ifid_valid, fetch_cnt);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_errors;
        mem_hash = 1'b1;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0, $urandom);
            tick();
            n_checks++;
            if (pc_o !== m_pc || ifid_pc !== m_ipc || ifid_pc4 !== m_ipc4 || ifid_inst !== m_inst ||
                ifid_valid !== m_valid || misalign_fault !== m_mis || fetch_cnt !== m_cnt) begin
                n_errors++;
                $display("FAIL random_%0d: pc=%h ipc=%h ipc4=%h inst=%h v=%b mis=%b cnt=%0d required %h %h %h %h %b %b %0d",
                         i, pc_o, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, misalign_fault, fetch_cnt,
                         m_pc, m_ipc, m_ipc4, m_inst, m_valid, m_mis, m_cnt);
            end
        end
        $display("random: 400 cycles, %0d new errors, final cnt=%0d", n_errors - errs_before, fetch_cnt);
        set_in(0, 0, 0, 0);
    endtask

    initial begin
        m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0; m_mis = 0; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_run();
        test_wrap();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
